// File: rtl/fwd_hazard_unit_if.sv
// ID-stage hazard/forwarding bus: decode-side operand and destination info in,
// stall request and registered EX forwarding selects out.
interface fwd_hazard_unit_if #(
    parameter int unsigned AW     = 5,
    parameter int unsigned STAGES = 2
);
    localparam int unsigned SW = $clog2(STAGES + 1);

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_addr;
    logic          id_is_load;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic [15:0]   stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, flush,
        input  stall, fwd_a, fwd_b, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, flush,
        output stall, fwd_a, fwd_b, stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit: tracks destinations of the
// instructions past EX, picks nearest-stage bypass selects and inserts bubbles.
module fwd_hazard_unit #(
    parameter int unsigned AW       = 5,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input logic              Clk,
    input logic              Reset,
    fwd_hazard_unit_if.slave bus
);
    localparam int unsigned SW = $clog2(STAGES + 1);

    typedef struct packed {
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic          isLoad;
    } slot_t;

    typedef enum logic {RUN, STALL} state_t;

    slot_t         pipe [STAGES];
    state_t        state;
    logic [SW-1:0] cnt;
    logic [SW-1:0] fwdA;
    logic [SW-1:0] fwdB;
    logic [15:0]   stallCnt;

    slot_t         idSlot;
    logic [SW-1:0] nearA;
    logic [SW-1:0] nearB;
    logic          loadA;
    logic          loadB;
    logic [SW-1:0] bubA;
    logic [SW-1:0] bubB;
    logic [SW-1:0] bubMax;
    logic          issue;
    logic          hazard;
    logic          stallInt;

    // Nearest matching producer per operand; descending scan lets the smallest stage win.
    always_comb begin
        nearA = '0;
        nearB = '0;
        loadA = 1'b0;
        loadB = 1'b0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (pipe[k].wrEn && (pipe[k].wrAddr == bus.id_rs) &&
                (bus.id_rs != '0) && bus.id_use_rs) begin
                nearA = SW'(k + 1);
                loadA = pipe[k].isLoad;
            end
            if (pipe[k].wrEn && (pipe[k].wrAddr == bus.id_rt) &&
                (bus.id_rt != '0) && bus.id_use_rt) begin
                nearB = SW'(k + 1);
                loadB = pipe[k].isLoad;
            end
        end
    end

    // Bubbles still owed before a loaded value reaches a forwardable stage.
    always_comb begin
        bubA = '0;
        bubB = '0;
        if (loadA && (nearA != '0) && (nearA <= SW'(LOAD_LAT)))
            bubA = SW'(LOAD_LAT + 1) - nearA;
        if (loadB && (nearB != '0) && (nearB <= SW'(LOAD_LAT)))
            bubB = SW'(LOAD_LAT + 1) - nearB;
        bubMax = (bubA > bubB) ? bubA : bubB;
    end

    always_comb begin
        issue    = bus.id_valid && !bus.flush;
        hazard   = (state == RUN) && issue && (bubMax != '0);
        stallInt = !Reset && !bus.flush && ((state == STALL) || hazard);
        idSlot   = '{wrEn: bus.id_wr_en, wrAddr: bus.id_wr_addr, isLoad: bus.id_is_load};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < int'(STAGES); k++) pipe[k] <= '0;
            state    <= RUN;
            cnt      <= '0;
            fwdA     <= '0;
            fwdB     <= '0;
            stallCnt <= '0;
        end else begin
            pipe[0] <= (issue && !stallInt) ? idSlot : '0;
            for (int k = 1; k < int'(STAGES); k++) pipe[k] <= pipe[k-1];

            fwdA <= (issue && !stallInt) ? nearA : '0;
            fwdB <= (issue && !stallInt) ? nearB : '0;

            // Multi-bubble loads park in STALL; a flush always abandons the stall.
            if (bus.flush) begin
                state <= RUN;
                cnt   <= '0;
            end else if (state == RUN) begin
                if (hazard && (bubMax > SW'(1))) begin
                    state <= STALL;
                    cnt   <= bubMax - SW'(1);
                end
            end else begin
                if (cnt <= SW'(1)) begin
                    state <= RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - SW'(1);
                end
            end

            if (stallInt && (stallCnt != 16'hFFFF))
                stallCnt <= stallCnt + 16'd1;
        end
    end

    assign bus.stall        = stallInt;
    assign bus.fwd_a        = fwdA;
    assign bus.fwd_b        = fwdB;
    assign bus.stall_cycles = stallCnt;
endmodule
